axilite_cmd_master: RTL and testbench

AXI4-Lite master that converts a simple one-command-at-a-time request/response interface into AXI4-Lite read and write transactions. It is the initiator counterpart of the AXI4-Lite slaves in the test systems, such as the SHA-256 slave. It is used by bench sequencers and on-fabric controllers to drive a slave directly without going through the packet-chain interface. At most one transaction is outstanding at any time.

---
 rtl/axilite_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_axilite_cmd_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_cmd_master.sv
// ----------------------------------------------------------------------------
// axilite_cmd_master
//
// AXI4-Lite master that turns a one-command-at-a-time request/response port
// into single AXI4-Lite read or write transactions. Only one transaction is
// ever outstanding. Every output is driven from a flop, so there is no
// combinational path from any input to any output.
//
// Optional feature macro: PRGA_AXILITE_MASTER_TIMEOUT_EN
//   When defined, the B/R wait states give up after TIMEOUT_CYCLES cycles and
//   return rsp_resp=2'b10 with rsp_timeout=1. When undefined, the master
//   waits indefinitely and rsp_timeout is tied low.
//
// Ports
//   ACLK, ARESETn       clock (rising edge), synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_wr              1 = write, 0 = read
//   cmd_addr/data/strb  transaction address, write data, write strobes
//   rsp_valid/ready     response handshake
//   rsp_data            read data (0 for writes and timeouts)
//   rsp_resp            BRESP/RRESP, or 2'b10 on timeout
//   rsp_timeout         response was produced by the timeout
//   AW*/W*/B*/AR*/R*    AXI4-Lite master channels; AWPROT/ARPROT tied to 0
// ----------------------------------------------------------------------------
`ifndef PRGA_AXI_ADDR_WIDTH
`define PRGA_AXI_ADDR_WIDTH 32
`endif
`ifndef PRGA_AXI_DATA_WIDTH
`define PRGA_AXI_DATA_WIDTH 32
`endif

module axilite_cmd_master #(
    parameter int ADDR_WIDTH     = `PRGA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `PRGA_AXI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t state, state_next;

    logic                    cmd_accept;
    logic                    aw_done, w_done;
    logic                    wr_addr_done, wr_data_done;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    assign cmd_accept = cmd_valid && cmd_ready;

    // A channel counts as done once its handshake has happened, whether on
    // this edge or an earlier one (the sticky flag).
    assign wr_addr_done = aw_done || (AWVALID && AWREADY);
    assign wr_data_done = w_done  || (WVALID && WREADY);

    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign WDATA  = data_q;
    assign WSTRB  = strb_q;
    assign AWPROT = 3'b000;
    assign ARPROT = 3'b000;

    // NOTE: state and all flops below use non-blocking assignments so every
    // register samples the pre-edge values; blocking here would create
    // order-dependent simulation that does not match the hardware.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_accept)                     state_next = cmd_wr ? WR_REQ : RD_REQ;
            WR_REQ:  if (wr_addr_done && wr_data_done)   state_next = WR_RESP;
            WR_RESP: if (BVALID || timeout_hit)          state_next = RSP;
            RD_REQ:  if (ARREADY)                        state_next = RD_DATA;
            RD_DATA: if (RVALID || timeout_hit)          state_next = RSP;
            RSP:     if (rsp_ready)                      state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so each one is
    // already high in the first cycle of its state.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cmd_ready <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            cmd_ready <= (state_next == IDLE);
            AWVALID   <= (state_next == WR_REQ) && !wr_addr_done;
            WVALID    <= (state_next == WR_REQ) && !wr_data_done;
            aw_done   <= (state_next == WR_REQ) && wr_addr_done;
            w_done    <= (state_next == WR_REQ) && wr_data_done;
            BREADY    <= (state_next == WR_RESP);
            ARVALID   <= (state_next == RD_REQ);
            RREADY    <= (state_next == RD_DATA);
            rsp_valid <= (state_next == RSP);
            if (state == WR_RESP && state_next == RSP) begin
                rsp_data <= '0;
                rsp_resp <= BVALID ? BRESP : 2'b10;
            end else if (state == RD_DATA && state_next == RSP) begin
                rsp_data <= RVALID ? RDATA : '0;
                rsp_resp <= RVALID ? RRESP : 2'b10;
            end
        end
    end

    // NOTE: the command datapath registers carry no reset; they are only
    // observed while a VALID that reset does clear is high, so resetting
    // them would only add reset fan-out.
    always_ff @(posedge ACLK) begin
        if (cmd_accept) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            strb_q <= cmd_strb;
        end
    end

`ifdef PRGA_AXILITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             rsp_timeout_q;

    assign in_wait     = (state == WR_RESP) || (state == RD_DATA);
    assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = rsp_timeout_q;

    // Counts cycles spent in the current B/R wait; restarts on each entry.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wait_cnt      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (!in_wait) wait_cnt <= '0;
            else          wait_cnt <= wait_cnt + 1'b1;
            if (in_wait && state_next == RSP)
                rsp_timeout_q <= !((state == WR_RESP && BVALID) || (state == RD_DATA && RVALID));
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axilite_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_axilite_cmd_master
//
// Self-checking bench for axilite_cmd_master (32-bit address/data,
// TIMEOUT_CYCLES=16). Directed table vectors carry hand-written expected
// results; random vectors take their expected results from a small
// transaction-level model. An AXI slave responder with programmable wait
// states runs cycle by cycle inside the transaction task.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axilite_cmd_master;

    localparam int TO = 16;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axilite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;  // slave wait cycles per channel
        logic [1:0]  resp;                       // BRESP / RRESP the slave returns
        logic [31:0] rdata;
        int          hold;                       // cycles rsp_ready stays low
        logic        to;                         // response expected from timeout
        int          exp_lat;                    // accept -> rsp_valid, in cycles
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a write finishes once both the address and
    // data phases are accepted and B arrives; a read once AR then R complete.
    // Three cycles of pipeline on top of the slave's waits.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.wr) begin
            r.exp_lat  = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
            r.exp_data = 32'h0;
        end else begin
            r.exp_lat  = 3 + v.ar_d + v.r_d;
            r.exp_data = v.rdata;
        end
        r.exp_resp = v.resp;
        r.to       = 1'b0;
        return r;
    endfunction

    task automatic slave_idle();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
        rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int   cyc, guard, lat;
        int   aw_n, w_n, b_n, ar_n, r_n;
        int   awv_c, wv_c, arv_c, bre_c, rre_c;
        int   aw_wait, w_wait, b_wait, ar_wait, r_wait, hold_left;
        int   bad_bus, bad_busy, bad_stable;
        bit   hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp, seen_rsp, done;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic        t0;

        cyc = 0; lat = -1; guard = 0;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        awv_c = 0; wv_c = 0; arv_c = 0; bre_c = 0; rre_c = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; hold_left = 0;
        bad_bus = 0; bad_busy = 0; bad_stable = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_rsp = 0;
        seen_rsp = 0; done = 0;
        d0 = '0; r0 = '0; t0 = 1'b0;

        @(negedge ACLK);
        while (!cmd_ready && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_data = v.data; cmd_strb = v.strb;

        while (!done && cyc < 200) begin
            @(negedge ACLK);
            cyc++;
            cmd_valid = 1'b0;
            if (hs_rsp) begin
                check("cmd_ready_after_rsp", cmd_ready, 1);
                check("rsp_valid_dropped", rsp_valid, 0);
                slave_idle();
                done = 1;
            end else begin
                if (hs_aw) aw_n++;
                if (hs_w)  w_n++;
                if (hs_b)  b_n++;
                if (hs_ar) ar_n++;
                if (hs_r)  r_n++;
                if (cmd_ready) bad_busy++;
                if (AWVALID) begin awv_c++; if (AWADDR !== v.addr) bad_bus++; end
                if (WVALID)  begin wv_c++;  if (WDATA !== v.data || WSTRB !== v.strb) bad_bus++; end
                if (ARVALID) begin arv_c++; if (ARADDR !== v.addr) bad_bus++; end
                if (BREADY)  bre_c++;
                if (RREADY)  rre_c++;

                AWREADY = AWVALID && (aw_wait >= v.aw_d);
                if (AWVALID && !AWREADY) aw_wait++;
                WREADY  = WVALID && (w_wait >= v.w_d);
                if (WVALID && !WREADY) w_wait++;
                ARREADY = ARVALID && (ar_wait >= v.ar_d);
                if (ARVALID && !ARREADY) ar_wait++;
                hs_aw = AWVALID && AWREADY;
                hs_w  = WVALID && WREADY;
                hs_ar = ARVALID && ARREADY;

                if (aw_n > 0 && w_n > 0 && b_n == 0) begin
                    BVALID = (b_wait >= v.b_d);
                    if (!BVALID) b_wait++;
                end else BVALID = 1'b0;
                BRESP = BVALID ? v.resp : 2'b00;
                hs_b  = BVALID && BREADY;

                if (ar_n > 0 && r_n == 0) begin
                    RVALID = (r_wait >= v.r_d);
                    if (!RVALID) r_wait++;
                end else RVALID = 1'b0;
                RDATA = RVALID ? v.rdata : 32'h0;
                RRESP = RVALID ? v.resp : 2'b00;
                hs_r  = RVALID && RREADY;

                if (rsp_valid) begin
                    if (!seen_rsp) begin
                        seen_rsp = 1; lat = cyc; hold_left = v.hold;
                        d0 = rsp_data; r0 = rsp_resp; t0 = rsp_timeout;
                    end else if (rsp_data !== d0 || rsp_resp !== r0 || rsp_timeout !== t0) begin
                        bad_stable++;
                    end
                    rsp_ready = (hold_left == 0);
                    if (hold_left > 0) hold_left--;
                end else rsp_ready = 1'b0;
                hs_rsp = rsp_valid && rsp_ready;
            end
        end
        slave_idle();

        check("txn_completed", done, 1);
        check("latency", lat, v.exp_lat);
        check("rsp_data", d0, v.exp_data);
        check("rsp_resp", r0, v.exp_resp);
        check("rsp_timeout", t0, v.to);
        check("aw_handshakes", aw_n, v.wr ? 1 : 0);
        check("w_handshakes", w_n, v.wr ? 1 : 0);
        check("b_handshakes", b_n, (v.wr && !v.to) ? 1 : 0);
        check("ar_handshakes", ar_n, v.wr ? 0 : 1);
        check("r_handshakes", r_n, (!v.wr && !v.to) ? 1 : 0);
        check("awvalid_cycles", awv_c, v.wr ? v.aw_d + 1 : 0);
        check("wvalid_cycles", wv_c, v.wr ? v.w_d + 1 : 0);
        check("arvalid_cycles", arv_c, v.wr ? 0 : v.ar_d + 1);
        check("bready_cycles", bre_c, !v.wr ? 0 : (v.to ? TO : v.b_d + 1));
        check("rready_cycles", rre_c, v.wr ? 0 : (v.to ? TO : v.r_d + 1));
        check("bus_stable", bad_bus, 0);
        check("cmd_ready_busy", bad_busy, 0);
        check("rsp_stable", bad_stable, 0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        // wr addr data strb aw w b ar r resp rdata hold to | lat data resp
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0, 3, 32'h0, 2'b00};
        vecs[1] = '{1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 3, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0, 6, 32'h0, 2'b00};
        vecs[2] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h12345678, 0, 1'b0, 8, 32'h12345678, 2'b00};
        vecs[3] = '{1'b1, 32'h30, 32'h01020304, 4'hF, 2, 0, 1, 0, 0, 2'b11, 32'h0, 10, 1'b0, 6, 32'h0, 2'b11};
        vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h0, 0, 0, 0, 3, 0, 2'b01, 32'hA5A5A5A5, 10, 1'b0, 6, 32'hA5A5A5A5, 2'b01};
        vecs[5] = '{1'b1, 32'h48, 32'h55AA55AA, 4'h5, 2, 2, 0, 0, 0, 2'b10, 32'h0, 0, 1'b0, 5, 32'h0, 2'b10};

        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        slave_idle();
        repeat (3) @(negedge ACLK);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("reset_rsp_fields", {rsp_data, rsp_resp, rsp_timeout}, 0);
        check("reset_prot", {AWPROT, ARPROT}, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("cmd_ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Reset while waiting for B: everything clears, then a read still works.
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h50; cmd_data = 32'h11223344; cmd_strb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        check("mid_reset_awvalid", AWVALID, 1);
        AWREADY = 1'b1; WREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0; WREADY = 1'b0;
        check("mid_reset_in_wr_resp", BREADY, 1);
        ARESETn = 1'b0;
        @(negedge ACLK);
        check("mid_reset_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready}, 0);
        check("mid_reset_rsp_fields", {rsp_data, rsp_resp, rsp_timeout}, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("mid_reset_cmd_ready", cmd_ready, 1);
        check("mid_reset_bready_low", BREADY, 0);
        rv = '{1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, 32'h0BADF00D, 0, 1'b0, 6, 32'h0BADF00D, 2'b00};
        run_txn(rv);

`ifdef PRGA_AXILITE_MASTER_TIMEOUT_EN
        // BVALID never arrives: response comes from the timeout after TO cycles.
        rv = '{1'b1, 32'h60, 32'h77777777, 4'hF, 0, 0, 1000, 0, 0, 2'b00, 32'h0, 2, 1'b1, TO + 2, 32'h0, 2'b10};
        run_txn(rv);
`endif

        for (int i = 0; i < 20; i++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.addr  = {$urandom_range(0, 255), 2'b00};
            rv.data  = $urandom;
            rv.strb  = 4'($urandom_range(0, 15));
            rv.aw_d  = $urandom_range(0, 4);
            rv.w_d   = $urandom_range(0, 4);
            rv.b_d   = $urandom_range(0, 4);
            rv.ar_d  = $urandom_range(0, 4);
            rv.r_d   = $urandom_range(0, 4);
            rv.resp  = 2'($urandom_range(0, 3));
            rv.rdata = $urandom;
            rv.hold  = $urandom_range(0, 2);
            run_txn(model(rv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
